// File: rtl/mem_write_pingpong_if.sv
// Write-side bus of mem_write_pingpong: per-channel beat handshake and the
// BRAM write port the accepted beats land on.
interface mem_write_pingpong_if #(
   parameter int D_W    = 32,
   parameter int N      = 4,
   parameter int ADDR_W = 12
);
   logic [N-1:0]            in_valid;
   logic [N*D_W-1:0]        in_data;
   logic [N-1:0]            in_ready;
   logic [N*(ADDR_W+1)-1:0] wr_addr_bram;
   logic [N*D_W-1:0]        wr_data_bram;
   logic [N-1:0]            wr_en_bram;

   modport master (
      output in_valid, in_data,
      input  in_ready, wr_addr_bram, wr_data_bram, wr_en_bram
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, wr_addr_bram, wr_data_bram, wr_en_bram
   );
endinterface

// File: rtl/mem_write_pingpong.sv
// Multi-channel result writer into a ping-pong BRAM region: each channel fills
// its slice of the active bank, then the bank is handed off and writing moves on.
module mem_write_pingpong #(
   parameter int D_W    = 32,
   parameter int N      = 4,
   parameter int ADDR_W = 12,
   parameter int LEN_W  = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [LEN_W-1:0]   i_len,
   mem_write_pingpong_if.slave bus,
   input  logic               i_bank_release,
   input  logic               i_release_bank,
   output logic               o_frame_done,
   output logic               o_done_bank,
   output logic [1:0]         o_bank_full
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [ADDR_W-1:0]          w_len_last;
   logic [ADDR_W-1:0]          r_len_last;
   logic                       r_wb;
   logic [1:0]                 r_bank_full;
   logic [1:0]                 w_bank_full_nxt;
   logic [N-1:0][ADDR_W-1:0]   r_cnt;
   logic [N-1:0]               r_ch_done;
   logic [N-1:0]               w_ready;
   logic [N-1:0]               w_accept;
   logic                       w_frame_end;

   // Store L-1 rather than L: it always fits in ADDR_W bits, including L = 2^ADDR_W.
   always_comb begin
      if (i_len == '0 || i_len > LEN_W'(DEPTH)) begin
         w_len_last = '1;
      end else begin
         w_len_last = ADDR_W'(i_len - 1'b1);
      end
   end

   assign w_frame_end = &r_ch_done;
   assign w_ready     = {N{~rst & ~r_bank_full[r_wb]}} & ~r_ch_done;
   assign w_accept    = bus.in_valid & w_ready;

   // The bank being marked full was never full before the edge, so a release
   // aimed at it is ignored simply by letting the set win.
   always_comb begin
      w_bank_full_nxt = r_bank_full;
      if (i_bank_release && r_bank_full[i_release_bank]) begin
         w_bank_full_nxt[i_release_bank] = 1'b0;
      end
      if (w_frame_end) begin
         w_bank_full_nxt[r_wb] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wb        <= 1'b0;
         r_bank_full <= 2'b00;
         r_ch_done   <= '0;
         r_cnt       <= '0;
         r_len_last  <= w_len_last;
      end else begin
         r_bank_full <= w_bank_full_nxt;
         for (int x = 0; x < N; x++) begin
            if (w_accept[x]) begin
               if (r_cnt[x] == r_len_last) begin
                  r_cnt[x]     <= '0;
                  r_ch_done[x] <= 1'b1;
               end else begin
                  r_cnt[x] <= r_cnt[x] + 1'b1;
               end
            end
         end
         if (w_frame_end) begin
            r_wb       <= ~r_wb;
            r_ch_done  <= '0;
            r_len_last <= w_len_last;
         end
      end
   end

   genvar g;
   generate
      for (g = 0; g < N; g++) begin : g_addr
         assign bus.wr_addr_bram[g*(ADDR_W+1) +: (ADDR_W+1)] = rst ? '0 : {r_wb, r_cnt[g]};
      end
   endgenerate

   assign bus.in_ready     = w_ready;
   assign bus.wr_en_bram   = w_accept;
   assign bus.wr_data_bram = bus.in_data;

   assign o_frame_done = w_frame_end & ~rst;
   assign o_done_bank  = r_wb;
   assign o_bank_full  = r_bank_full;

endmodule

// File: tb/tb_mem_write_pingpong.sv
// Scoreboard bench for mem_write_pingpong: expected BRAM writes are queued per
// channel as frames are planned and popped as the DUT writes them.
module tb_mem_write_pingpong;
   localparam int D_W    = 32;
   localparam int N      = 4;
   localparam int ADDR_W = 12;
   localparam int LEN_W  = 16;
   localparam int AW     = ADDR_W + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst = 1'b1;
   logic [LEN_W-1:0] len = '0;
   logic             bank_release = 1'b0;
   logic             release_bank = 1'b0;
   logic             frame_done;
   logic             done_bank;
   logic [1:0]       bank_full;

   mem_write_pingpong_if #(.D_W(D_W), .N(N), .ADDR_W(ADDR_W)) bus ();

   mem_write_pingpong #(.D_W(D_W), .N(N), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .i_len          (len),
      .bus            (bus),
      .i_bank_release (bank_release),
      .i_release_bank (release_bank),
      .o_frame_done   (frame_done),
      .o_done_bank    (done_bank),
      .o_bank_full    (bank_full)
   );

   typedef struct packed {
      logic [AW-1:0]  addr;
      logic [D_W-1:0] data;
      logic           last;
   } exp_t;

   exp_t sb_q[N][$];

   int n_cmp = 0;
   int n_err = 0;

   logic             tb_rst = 1'b1;
   logic [LEN_W-1:0] tb_len = '0;
   logic             tb_rel = 1'b0;
   logic             tb_rb  = 1'b0;
   int               rem[N];
   int               per[N];
   int               dseq[N];
   int               sseq[N];
   int               cyc;
   logic [N-1:0]     v_drv;
   logic [N-1:0]     fin;
   logic             fin_bank;
   logic             fd_exp;
   logic             fd_bank_exp;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [D_W-1:0] dval(input int x, input int s);
      return (D_W'(x) << 28) | 32'h0A00_0000 | (D_W'(s) & 32'h00FF_FFFF);
   endfunction

   task automatic push_frame(input logic bank, input int l, input int cnt);
      exp_t e;
      for (int x = 0; x < N; x++) begin
         for (int i = 0; i < cnt; i++) begin
            e.addr = {bank, ADDR_W'(i)};
            e.data = dval(x, sseq[x]);
            e.last = (i == l - 1);
            sseq[x]++;
            sb_q[x].push_back(e);
         end
      end
   endtask

   task automatic mon();
      exp_t e;
      for (int x = 0; x < N; x++) begin
         if (bus.wr_en_bram[x]) begin
            if (sb_q[x].size() == 0) begin
               check_val($sformatf("sb_unexpected_write_ch%0d", x), 64'(sb_q[x].size()), 64'd1);
            end else begin
               e = sb_q[x].pop_front();
               check_val($sformatf("wr_addr_ch%0d", x), 64'(bus.wr_addr_bram[x*AW +: AW]), 64'(e.addr));
               check_val($sformatf("wr_data_ch%0d", x), 64'(bus.wr_data_bram[x*D_W +: D_W]), 64'(e.data));
               if (e.last) begin
                  fin[x]   = 1'b1;
                  fin_bank = e.addr[AW-1];
               end
            end
         end
      end
      if (fd_exp || frame_done) begin
         check_val("frame_done", 64'(frame_done), 64'(fd_exp));
         if (fd_exp) check_val("done_bank", 64'(done_bank), 64'(fd_bank_exp));
      end
      fd_exp = &fin;
      if (&fin) begin
         fd_bank_exp = fin_bank;
         fin         = '0;
      end
   endtask

   task automatic step();
      logic [N*D_W-1:0] d;
      @(posedge clk);
      #1;
      rst          = tb_rst;
      len          = tb_len;
      bank_release = tb_rel;
      release_bank = tb_rb;
      d = '0;
      for (int x = 0; x < N; x++) begin
         v_drv[x] = (rem[x] > 0) && (cyc % per[x] == 0);
         d[x*D_W +: D_W] = dval(x, dseq[x]);
      end
      bus.in_valid = v_drv;
      bus.in_data  = d;
      cyc++;
      @(negedge clk);
      mon();
      for (int x = 0; x < N; x++) begin
         if (v_drv[x] && bus.in_ready[x]) begin
            rem[x]--;
            dseq[x]++;
         end
      end
   endtask

   task automatic reset_dut(input logic [LEN_W-1:0] l);
      tb_len = l;
      tb_rst = 1'b1;
      tb_rel = 1'b0;
      for (int x = 0; x < N; x++) rem[x] = 0;
      step();
      for (int x = 0; x < N; x++) begin
         sb_q[x].delete();
         sseq[x] = dseq[x];
         per[x]  = 1;
      end
      fin    = '0;
      fd_exp = 1'b0;
      tb_rst = 1'b0;
      cyc    = 0;
   endtask

   task automatic set_rem(input int r);
      for (int x = 0; x < N; x++) rem[x] = r;
   endtask

   task automatic check_drained(input string tag);
      for (int x = 0; x < N; x++)
         check_val($sformatf("%s_left_ch%0d", tag, x), 64'(sb_q[x].size()), 64'd0);
   endtask

   initial begin
      bus.in_valid = '0;
      bus.in_data  = '0;
      v_drv = '0; fin = '0; fin_bank = 1'b0; fd_exp = 1'b0; fd_bank_exp = 1'b0; cyc = 0;
      for (int x = 0; x < N; x++) begin
         rem[x] = 0; per[x] = 1; dseq[x] = 0; sseq[x] = 0;
      end

      // Reset values
      tb_len = 16'd3;
      step();
      step();
      check_val("rst_in_ready", 64'(bus.in_ready), 64'd0);
      check_val("rst_wr_en", 64'(bus.wr_en_bram), 64'd0);
      check_val("rst_frame_done", 64'(frame_done), 64'd0);
      check_val("rst_bank_full", 64'(bank_full), 64'd0);
      check_val("rst_wr_addr", 64'(bus.wr_addr_bram), 64'd0);

      // len=3, all channels streaming, two frames then release both banks
      reset_dut(16'd3);
      push_frame(1'b0, 3, 3);
      push_frame(1'b1, 3, 3);
      set_rem(6);
      for (int c = 0; c < 12; c++) begin
         tb_rel = (c == 9) || (c == 10);
         tb_rb  = (c == 10);
         step();
         if (c == 3) begin
            check_val("t1_fd_c3", 64'(frame_done), 64'd1);
            check_val("t1_done_bank_c3", 64'(done_bank), 64'd0);
         end
         if (c == 4) begin
            check_val("t1_bank_full_c4", 64'(bank_full), 64'b01);
            check_val("t1_addr_c4", 64'(bus.wr_addr_bram[0 +: AW]), 64'h1000);
         end
         if (c == 8)  check_val("t1_bank_full_c8", 64'(bank_full), 64'b11);
         if (c == 11) check_val("t1_bank_full_c11", 64'(bank_full), 64'b00);
      end
      tb_rel = 1'b0;
      check_drained("t1");

      // Skewed channels, len=4
      reset_dut(16'd4);
      per[1] = 2;
      per[3] = 3;
      push_frame(1'b0, 4, 4);
      set_rem(4);
      for (int c = 0; c < 12; c++) begin
         step();
         if (c == 4)  check_val("t2_ch0_ready_c4", 64'(bus.in_ready[0]), 64'd0);
         if (c == 9)  check_val("t2_fd_c9", 64'(frame_done), 64'd0);
         if (c == 10) check_val("t2_fd_c10", 64'(frame_done), 64'd1);
      end
      check_drained("t2");

      // No release, len=2: both banks fill and writers stall
      reset_dut(16'd2);
      push_frame(1'b0, 2, 2);
      push_frame(1'b1, 2, 2);
      push_frame(1'b0, 2, 2);
      set_rem(6);
      for (int c = 0; c < 21; c++) begin
         tb_rel = (c == 16) || (c == 19);
         tb_rb  = (c == 19);
         step();
         if (c >= 6 && c <= 16) begin
            check_val($sformatf("t3_stall_ready_c%0d", c), 64'(bus.in_ready), 64'd0);
            check_val($sformatf("t3_stall_wr_en_c%0d", c), 64'(bus.wr_en_bram), 64'd0);
         end
         if (c == 6) check_val("t3_bank_full_c6", 64'(bank_full), 64'b11);
         if (c == 17) begin
            check_val("t3_ready_c17", 64'(bus.in_ready), 64'hF);
            check_val("t3_addr_c17", 64'(bus.wr_addr_bram[0 +: AW]), 64'h0000);
         end
         if (c == 20) check_val("t3_bank_full_c20", 64'(bank_full), 64'b01);
      end
      tb_rel = 1'b0;
      check_drained("t3");

      // len 5 -> 2 mid-frame
      reset_dut(16'd5);
      push_frame(1'b0, 5, 5);
      push_frame(1'b1, 2, 2);
      set_rem(7);
      for (int c = 0; c < 10; c++) begin
         if (c == 2) tb_len = 16'd2;
         step();
         if (c == 5) check_val("t4_fd_c5", 64'(frame_done), 64'd1);
         if (c == 8) check_val("t4_fd_c8", 64'(frame_done), 64'd1);
      end
      check_drained("t4");

      // len=0 means a full 4096-word bank
      reset_dut(16'd0);
      push_frame(1'b0, 4096, 4096);
      push_frame(1'b1, 4096, 2);
      set_rem(4098);
      for (int c = 0; c < 4100; c++) begin
         step();
         if (c == 4095) check_val("t5_addr_c4095", 64'(bus.wr_addr_bram[0 +: AW]), 64'h0FFF);
         if (c == 4096) check_val("t5_fd_c4096", 64'(frame_done), 64'd1);
      end
      check_drained("t5");

      // Reset mid-frame after 2 of 4 beats
      reset_dut(16'd4);
      push_frame(1'b0, 4, 4);
      set_rem(4);
      step();
      step();
      tb_rst = 1'b1;
      step();
      check_val("t6_rst_ready", 64'(bus.in_ready), 64'd0);
      check_val("t6_rst_wr_en", 64'(bus.wr_en_bram), 64'd0);
      reset_dut(16'd4);
      step();
      check_val("t6_post_bank_full", 64'(bank_full), 64'd0);
      check_val("t6_post_fd", 64'(frame_done), 64'd0);
      check_val("t6_post_addr", 64'(bus.wr_addr_bram), 64'd0);
      check_val("t6_post_ready", 64'(bus.in_ready), 64'hF);
      push_frame(1'b0, 4, 4);
      set_rem(4);
      for (int c = 0; c < 7; c++) step();
      check_drained("t6");

      // Release of a free bank, and of bank 0 in its own frame_done cycle
      reset_dut(16'd2);
      push_frame(1'b0, 2, 2);
      set_rem(2);
      for (int c = 0; c < 4; c++) begin
         tb_rel = (c == 0) || (c == 2);
         tb_rb  = (c == 0);
         step();
         if (c == 1) check_val("t7_bank_full_c1", 64'(bank_full), 64'b00);
         if (c == 2) check_val("t7_fd_c2", 64'(frame_done), 64'd1);
         if (c == 3) check_val("t7_bank_full_c3", 64'(bank_full), 64'b01);
      end
      tb_rel = 1'b0;
      check_drained("t7");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/mem_write_pingpong.md
# mem_write_pingpong

Multi-channel result writer that streams N parallel output channels into a double-buffered (ping-pong) BRAM region. Each channel has its own address counter and stall-free valid/ready handshake. A frame completes when every channel has written its programmed word count. The block then hands the filled bank to the downstream reader and continues into the other bank, stalling writers only while both banks are full. It sits between the compute array outputs and the result BRAMs and supersedes the single-bank wrap-around writer.

## Interface
- D_W, 32, data width per channel
- N, 4, channel count (≥1)
- ADDR_W, 12, per-bank word address width; BRAM address is ADDR_W+1 bits with the bank bit as MSB
- LEN_W, 16, width of frame length input (≥ ADDR_W+1)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- len  in  LEN_W  words per channel per frame; sampled into len_q at reset and at each frame swap
- in_valid  in  N  per-channel beat valid
- in_data  in  N*D_W  per-channel data, channel x at [x*D_W +: D_W]
- in_ready  out  N  per-channel accept
- wr_addr_bram  out  N*(ADDR_W+1)  per-channel BRAM address {bank, cnt}
- wr_data_bram  out  N*D_W  BRAM write data (= in_data)
- wr_en_bram  out  N  BRAM write enable
- bank_release  in  1  consumer frees a bank (1-cycle pulse)
- release_bank  in  1  index of the bank being freed
- frame_done  out  1  1-cycle pulse, frame written
- done_bank  out  1  bank that frame_done refers to
- bank_full  out  2  per-bank full status

## Operation
- State: write bank wb, bank_full[1:0], per-channel cnt[x] (ADDR_W bits), per-channel ch_done[x], len_q.
- len_q is the effective length L. If len is 0 or > 2^ADDR_W, L = 2^ADDR_W; otherwise L = len. len changes mid-frame have no effect.
- in_ready[x] = !rst & !bank_full[wb] & !ch_done[x].
- accept[x] = in_valid[x] & in_ready[x]. This is combinational:
  - wr_en_bram[x] = accept[x]
  - wr_addr_bram[x] = {wb, cnt[x]}
  - wr_data_bram passes in_data through unconditionally.
- On accept[x]:
  - if cnt[x] == L-1: cnt[x] <= 0 and ch_done[x] <= 1
  - otherwise: cnt[x] <= cnt[x]+1
- Channels progress independently. A fast channel idles with in_ready low after finishing its quota.
- Frame end: when all ch_done are 1 (FRAME_END cycle):
  - frame_done = 1, done_bank = wb
  - at that edge: bank_full[wb] <= 1, wb <= ~wb, all ch_done <= 0, len_q reloaded from len
- Release: on an edge with bank_release = 1, bank_full[release_bank] <= 0 if it was 1 before the edge. Release of a non-full bank is ignored, including the bank being marked full at that same edge.
- Release and frame end on different banks at the same edge: both take effect.
- Both banks full: all in_ready low until a release. Data on in_valid during the stall is not written.

## Timing
- Write latency 0: the BRAM write happens on the edge the beat is accepted.
- Last outstanding final beat accepted in cycle k: frame_done is high in cycle k+1 only. Beats for the new bank are accepted from cycle k+2 if that bank is free.
- Release in cycle r: the freed bank is usable from cycle r+1.
- Reset (any cycle, including mid-frame; the partial frame is discarded):
  - cnt = 0, ch_done = 0, wb = 0, bank_full = 00
  - frame_done = 0, done_bank = 0, len_q loaded
  - wr_en_bram = 0 and in_ready = 0 while rst is high
  - wr_addr_bram = {0,0} for all channels
- Throughput: 1 beat/cycle/channel, apart from the single FRAME_END bubble.

## Test plan
- N=4, len=3, all valid continuously:
  - each channel writes addrs 0,1,2 (bank bit 0) in cycles 0-2
  - frame_done high in cycle 3 with done_bank=0
  - addresses 0x1000,0x1001,… from cycle 4; bank_full=01 after cycle 3
- Skewed channels, len=4 (ch0 every cycle, ch3 every 3rd cycle):
  - ch0 in_ready drops after 4 beats
  - frame_done occurs only the cycle after ch3's 4th beat
  - no address exceeds 3
- No release, len=2: frames 0 and 1 fill banks 0 and 1, then bank_full=11 and in_ready=0 for 10 cycles with valid high, no wr_en. Release bank 0 -> in_ready rises next cycle, writes go to addr 0x0000.
- len changed from 5 to 2 mid-frame: the current frame still writes 5 words/channel, the next frame 2. len=0 -> 4096 words/channel, counter wraps 4095->0 with ch_done set.
- rst asserted mid-frame after 2 of 4 beats: outputs at reset values next cycle, the next frame restarts at bank 0 addr 0, and no frame_done is produced for the aborted frame.
- Release of a free bank, and release of bank 0 in its own frame_done cycle: both ignored, bank_full[0] stays 1.
